// File: rtl/riscv_fetch_align.sv
// riscv_fetch_align: splits fetch words into 16-bit parcels, queues them and
// hands one 32-bit or compressed 16-bit instruction per handshake to the
// decoder, tracking the PC of each instruction. Redirects flush the queue.
//
// Build option: define RISCV_ISA_C_EN to enable compressed (RVC) support.
// Without it, every instruction is 32 bits, redirects are word-granular and
// parcels that look compressed are flagged on ins_ill.
module riscv_fetch_align #(
    parameter int             IFW    = 32,
    parameter int             PCW    = 32,
    parameter int             QD     = 8,
    parameter logic [PCW-1:0] RST_PC = PCW'(32'h8000_0000)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fch_vld,
    output logic           fch_rdy,
    input  logic [IFW-1:0] fch_dat,
    input  logic           jmp_vld,
    input  logic [PCW-1:0] jmp_adr,
    output logic           ins_vld,
    input  logic           ins_rdy,
    output logic [31:0]    ins_dat,
    output logic [PCW-1:0] ins_pc,
    output logic           ins_cmp,
    output logic           ins_ill
);

    localparam int NP = IFW / 16;           // parcels per fetch word
    localparam int OW = (NP > 2) ? 2 : 1;   // parcel offset width
    localparam int AW = $clog2(QD);
    localparam int CW = AW + 1;

    logic [15:0]    q [QD];
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  wptr;
    logic [CW-1:0]  count;
    logic [PCW-1:0] pc;
    logic [OW-1:0]  skip;

    logic [15:0]    h0;
    logic [15:0]    h1;
    logic           is_c;
    logic [1:0]     need;
    logic           push;
    logic           pop;
    logic [CW-1:0]  n_push;
    logic [CW-1:0]  n_pop;

    // Parcel offset of an address inside its fetch word; without RVC only
    // whole 32-bit slots can be targeted.
    function automatic logic [OW-1:0] word_off(input logic [PCW-1:0] a);
        logic [OW-1:0] o;
        o = a[OW:1];
`ifndef RISCV_ISA_C_EN
        o[0] = 1'b0;
`endif
        return o;
    endfunction

    function automatic logic [PCW-1:0] align_pc(input logic [PCW-1:0] a);
`ifdef RISCV_ISA_C_EN
        return {a[PCW-1:1], 1'b0};
`else
        return {a[PCW-1:2], 2'b00};
`endif
    endfunction

    // Instruction extraction from the queue head, plus handshake qualifiers.
    always_comb begin
        h0   = q[rptr];
        h1   = q[rptr + AW'(1)];
        is_c = (h0[1:0] != 2'b11);
`ifdef RISCV_ISA_C_EN
        need    = is_c ? 2'd1 : 2'd2;
        ins_dat = is_c ? {16'h0000, h0} : {h1, h0};
`else
        need    = 2'd2;
        ins_dat = {h1, h0};
`endif
        ins_vld = (count >= CW'(need));
`ifdef RISCV_ISA_C_EN
        ins_cmp = ins_vld & is_c;
        ins_ill = 1'b0;
`else
        ins_cmp = 1'b0;
        ins_ill = ins_vld & is_c;
`endif
        ins_pc  = pc;
        // Registered-only: a pop in this cycle does not open the fetch side.
        fch_rdy = (count <= CW'(QD - NP));
        push    = fch_vld & fch_rdy & ~jmp_vld;
        pop     = ins_vld & ins_rdy & ~jmp_vld;
        n_push  = push ? (CW'(NP) - CW'(skip)) : '0;
        n_pop   = pop ? CW'(need) : '0;
    end

    // Parcel storage: write the kept parcels of an accepted fetch word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QD; i++) q[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < NP; i++) begin
                if (i >= int'(skip))
                    q[wptr + AW'(i) - AW'(skip)] <= fch_dat[16*i +: 16];
            end
        end
    end

    // Pointers, occupancy, PC and skip; a redirect overrides both handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            pc    <= {RST_PC[PCW-1:1], 1'b0};
            skip  <= word_off(RST_PC);
        end else if (jmp_vld) begin
            rptr  <= wptr;
            count <= '0;
            pc    <= align_pc(jmp_adr);
            skip  <= word_off(jmp_adr);
        end else begin
            if (push) begin
                wptr <= wptr + AW'(n_push);
                skip <= '0;
            end
            if (pop) begin
                rptr <= rptr + AW'(need);
                pc   <= pc + PCW'({need, 1'b0});
            end
            count <= count + n_push - n_pop;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Bench for riscv_fetch_align: a 32-bit-fetch instance carries most scenarios
// through an expected-instruction queue; a 64-bit-fetch instance covers the
// wide redirect. Expectations follow RISCV_ISA_C_EN when it is defined.
module tb_riscv_fetch_align;

`ifdef RISCV_ISA_C_EN
    localparam bit C_EN = 1'b1;
`else
    localparam bit C_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] pc;
        logic        cmp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        fch_vld, fch_rdy, jmp_vld, ins_vld, ins_rdy, ins_cmp, ins_ill;
    logic [31:0] fch_dat, jmp_adr, ins_dat, ins_pc;

    logic        fch_vld_w, fch_rdy_w, jmp_vld_w, ins_vld_w, ins_rdy_w, ins_cmp_w, ins_ill_w;
    logic [63:0] fch_dat_w;
    logic [31:0] jmp_adr_w, ins_dat_w, ins_pc_w;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    riscv_fetch_align #(.IFW(32), .PCW(32), .QD(8), .RST_PC(32'h8000_0000)) u32 (
        .clk(clk), .rst_n(rst_n),
        .fch_vld(fch_vld), .fch_rdy(fch_rdy), .fch_dat(fch_dat),
        .jmp_vld(jmp_vld), .jmp_adr(jmp_adr),
        .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_dat(ins_dat),
        .ins_pc(ins_pc), .ins_cmp(ins_cmp), .ins_ill(ins_ill)
    );

    riscv_fetch_align #(.IFW(64), .PCW(32), .QD(8), .RST_PC(32'h8000_0000)) u64 (
        .clk(clk), .rst_n(rst_n),
        .fch_vld(fch_vld_w), .fch_rdy(fch_rdy_w), .fch_dat(fch_dat_w),
        .jmp_vld(jmp_vld_w), .jmp_adr(jmp_adr_w),
        .ins_vld(ins_vld_w), .ins_rdy(ins_rdy_w), .ins_dat(ins_dat_w),
        .ins_pc(ins_pc_w), .ins_cmp(ins_cmp_w), .ins_ill(ins_ill_w)
    );

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input logic [31:0] dat, input logic [31:0] pc,
                            input logic cmp, input logic ill);
        exp_t e;
        e.dat = dat; e.pc = pc; e.cmp = cmp; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] w);
        int cyc = 0;
        @(negedge clk);
        fch_vld = 1'b1;
        fch_dat = w;
        while (!fch_rdy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!fch_rdy) begin
            n_vec++; n_err++;
            $display("FAIL fetch_accept actual=fch_rdy 0 required=accepted within 20 cycles");
        end else begin
            @(posedge clk);
        end
        #1 fch_vld = 1'b0;
    endtask

    // Pop n instructions from the DUT, comparing each against the queue.
    task automatic drain(input string tag, input int n);
        int   got = 0;
        int   cyc = 0;
        exp_t e;
        while (got < n && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ins_vld) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s unexpected actual=%h required=none", tag, ins_dat);
                end else begin
                    e = exp_q.pop_front();
                    if (ins_dat !== e.dat) begin
                        n_err++;
                        $display("FAIL %s dat actual=%h required=%h", tag, ins_dat, e.dat);
                    end
                    n_vec++;
                    if (ins_pc !== e.pc) begin
                        n_err++;
                        $display("FAIL %s pc actual=%h required=%h", tag, ins_pc, e.pc);
                    end
                    n_vec++;
                    if (ins_cmp !== e.cmp || ins_ill !== e.ill) begin
                        n_err++;
                        $display("FAIL %s cmp/ill actual=%b%b required=%b%b",
                                 tag, ins_cmp, ins_ill, e.cmp, e.ill);
                    end
                end
                ins_rdy = 1'b1;
                @(posedge clk);
                #1 ins_rdy = 1'b0;
                got++;
            end
        end
        if (got < n) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout actual=%0d required=%0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fch_vld = 0; fch_dat = '0; jmp_vld = 0; jmp_adr = '0; ins_rdy = 0;
        fch_vld_w = 0; fch_dat_w = '0; jmp_vld_w = 0; jmp_adr_w = '0; ins_rdy_w = 0;
        #12;
        n_vec++;
        if (ins_vld !== 1'b0 || fch_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hs actual=vld%b rdy%b required=vld0 rdy1", ins_vld, fch_rdy);
        end
        n_vec++;
        if (ins_pc !== 32'h8000_0000 || ins_dat !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pc actual=%h/%h required=80000000/00000000", ins_pc, ins_dat);
        end
        n_vec++;
        if (ins_cmp !== 1'b0 || ins_ill !== 1'b0 || fch_rdy_w !== 1'b1 || ins_pc_w !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL reset_misc actual=%b%b%b %h required=001 80000000",
                     ins_cmp, ins_ill, fch_rdy_w, ins_pc_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word32();
        push_exp(32'h00A0_0513, 32'h8000_0000, 1'b0, 1'b0);
        fetch(32'h00A0_0513);
        @(negedge clk);
        n_vec++;
        if (ins_vld !== 1'b1) begin
            n_err++;
            $display("FAIL latency actual=%b required=1", ins_vld);
        end
        drain("word32", 1);
        @(negedge clk);
        n_vec++;
        if (ins_pc !== 32'h8000_0004 || ins_vld !== 1'b0) begin
            n_err++;
            $display("FAIL word32_after actual=%h vld%b required=80000004 vld0", ins_pc, ins_vld);
        end
    endtask

    task automatic test_two_compressed();
        int n;
        if (C_EN) begin
            push_exp(32'h0000_4501, 32'h8000_0004, 1'b1, 1'b0);
            push_exp(32'h0000_4505, 32'h8000_0006, 1'b1, 1'b0);
            n = 2;
        end else begin
            push_exp(32'h4505_4501, 32'h8000_0004, 1'b0, 1'b1);
            n = 1;
        end
        fetch(32'h4505_4501);
        drain("two_c", n);
        @(negedge clk);
        n_vec++;
        if (ins_pc !== 32'h8000_0008) begin
            n_err++;
            $display("FAIL two_c_pc actual=%h required=80000008", ins_pc);
        end
    endtask

    task automatic test_straddle();
        if (C_EN) push_exp(32'h0000_4501, 32'h8000_0008, 1'b1, 1'b0);
        else      push_exp(32'h0513_4501, 32'h8000_0008, 1'b0, 1'b1);
        fetch(32'h0513_4501);
        drain("straddle_a", 1);
        @(negedge clk);
        n_vec++;
        if (ins_vld !== 1'b0) begin
            n_err++;
            $display("FAIL straddle_wait actual=%b required=0", ins_vld);
        end
        if (C_EN) begin
            push_exp(32'h00A0_0513, 32'h8000_000A, 1'b0, 1'b0);
            push_exp(32'h0000_4501, 32'h8000_000E, 1'b1, 1'b0);
        end else begin
            push_exp(32'h4501_00A0, 32'h8000_000C, 1'b0, 1'b1);
        end
        fetch(32'h4501_00A0);
        drain("straddle_b", C_EN ? 2 : 1);
        @(negedge clk);
        n_vec++;
        if (ins_pc !== 32'h8000_0010 || ins_vld !== 1'b0) begin
            n_err++;
            $display("FAIL straddle_end actual=%h vld%b required=80000010 vld0", ins_pc, ins_vld);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        ins_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = {12'(i + 1), 20'h00093};
            push_exp(w, 32'h8000_0010 + 32'(4 * i), 1'b0, 1'b0);
            fetch(w);
        end
        @(negedge clk);
        n_vec++;
        if (fch_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full actual=%b required=0", fch_rdy);
        end
        fch_vld = 1'b1;
        fch_dat = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        n_vec++;
        if (fch_rdy !== 1'b0 || ins_vld !== 1'b1 || ins_dat !== 32'h0010_0093) begin
            n_err++;
            $display("FAIL bp_hold actual=rdy%b vld%b %h required=rdy0 vld1 00100093",
                     fch_rdy, ins_vld, ins_dat);
        end
        fch_vld = 1'b0;
        drain("bp_first", 1);
        @(negedge clk);
        n_vec++;
        if (fch_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_reopen actual=%b required=1", fch_rdy);
        end
        drain("bp_rest", 3);
    endtask

    task automatic test_redirect32();
        logic [31:0] tgt_pc;
        tgt_pc = C_EN ? 32'h8000_0106 : 32'h8000_0104;
        fetch(32'h0000_0013);
        @(negedge clk);
        jmp_vld = 1'b1; jmp_adr = 32'h8000_0106;
        fch_vld = 1'b1; fch_dat = 32'h1234_5678;
        ins_rdy = 1'b1;
        @(posedge clk);
        #1 jmp_vld = 1'b0; fch_vld = 1'b0; ins_rdy = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ins_vld !== 1'b0 || ins_pc !== tgt_pc) begin
            n_err++;
            $display("FAIL jmp32_flush actual=vld%b %h required=vld0 %h", ins_vld, ins_pc, tgt_pc);
        end
        if (C_EN) push_exp(32'h0000_4505, 32'h8000_0106, 1'b1, 1'b0);
        else      push_exp(32'h4505_FFFF, 32'h8000_0104, 1'b0, 1'b0);
        fetch(32'h4505_FFFF);
        drain("jmp32", 1);
        @(negedge clk);
        n_vec++;
        if (ins_vld !== 1'b0) begin
            n_err++;
            $display("FAIL jmp32_empty actual=%b required=0", ins_vld);
        end
    endtask

    task automatic test_redirect64();
        logic [31:0] e_dat, e_pc;
        logic        e_cmp;
        e_dat = C_EN ? 32'h0000_4505 : 32'h4505_FFFF;
        e_pc  = C_EN ? 32'h8000_0106 : 32'h8000_0104;
        e_cmp = C_EN;
        @(negedge clk);
        fch_vld_w = 1'b1; fch_dat_w = 64'h0000_0013_0000_0013;
        @(posedge clk);
        #1 fch_vld_w = 1'b0;
        @(negedge clk);
        jmp_vld_w = 1'b1; jmp_adr_w = 32'h8000_0106;
        fch_vld_w = 1'b1; fch_dat_w = 64'h0000_0000_0000_4501;
        ins_rdy_w = 1'b1;
        @(posedge clk);
        #1 jmp_vld_w = 1'b0; fch_vld_w = 1'b0; ins_rdy_w = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ins_vld_w !== 1'b0 || fch_rdy_w !== 1'b1) begin
            n_err++;
            $display("FAIL jmp64_flush actual=vld%b rdy%b required=vld0 rdy1", ins_vld_w, fch_rdy_w);
        end
        fch_vld_w = 1'b1; fch_dat_w = 64'h4505_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1 fch_vld_w = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ins_vld_w !== 1'b1 || ins_dat_w !== e_dat || ins_pc_w !== e_pc ||
            ins_cmp_w !== e_cmp || ins_ill_w !== 1'b0) begin
            n_err++;
            $display("FAIL jmp64_ins actual=vld%b %h @%h c%b i%b required=vld1 %h @%h c%b i0",
                     ins_vld_w, ins_dat_w, ins_pc_w, ins_cmp_w, ins_ill_w, e_dat, e_pc, e_cmp);
        end
        ins_rdy_w = 1'b1;
        @(posedge clk);
        #1 ins_rdy_w = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ins_vld_w !== 1'b0 || ins_pc_w !== 32'h8000_0108) begin
            n_err++;
            $display("FAIL jmp64_after actual=vld%b %h required=vld0 80000108", ins_vld_w, ins_pc_w);
        end
    endtask

    task automatic test_midreset();
        fetch(32'h00A0_0513);
        @(negedge clk);
        n_vec++;
        if (ins_vld !== 1'b1) begin
            n_err++;
            $display("FAIL mr_pre actual=%b required=1", ins_vld);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (ins_vld !== 1'b0 || ins_pc !== 32'h8000_0000 || fch_rdy !== 1'b1 || ins_dat !== 32'h0) begin
            n_err++;
            $display("FAIL mr_async actual=vld%b %h rdy%b %h required=vld0 80000000 rdy1 00000000",
                     ins_vld, ins_pc, fch_rdy, ins_dat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (ins_vld !== 1'b0) begin
            n_err++;
            $display("FAIL mr_after actual=%b required=0", ins_vld);
        end
    endtask

    initial begin
        test_reset();
        test_word32();
        test_two_compressed();
        test_straddle();
        test_backpressure();
        test_redirect32();
        test_redirect64();
        test_midreset();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
